// File: rtl/cc_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// cc_frame_ctrl_if
//   Handshake bundle for the frame controller: the upstream pixel valid/ready
//   pair and the downstream object-record valid/ready port with its payload.
//
//   master : controller side (drives pix_ready and the record port)
//   slave  : environment side (drives pix_valid and rec_ready)
//
//   pix_valid  upstream pixel available
//   pix_ready  controller accepts a pixel this cycle
//   rec_valid  object record available
//   rec_ready  downstream accepts the record
//   rec_id     record label
//   rec_area   record area
//   rec_x      record x-sum
//   rec_y      record y-sum
// -----------------------------------------------------------------------------
interface cc_frame_ctrl_if #(
    parameter int LOC_SIZE  = 10,
    parameter int LBL_WIDTH = 8
);
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 rec_valid;
    logic                 rec_ready;
    logic [LBL_WIDTH-1:0] rec_id;
    logic [LOC_SIZE-1:0]  rec_area;
    logic [LOC_SIZE-1:0]  rec_x;
    logic [LOC_SIZE-1:0]  rec_y;

    modport master (
        input  pix_valid, rec_ready,
        output pix_ready, rec_valid, rec_id, rec_area, rec_x, rec_y
    );

    modport slave (
        output pix_valid, rec_ready,
        input  pix_ready, rec_valid, rec_id, rec_area, rec_x, rec_y
    );
endinterface

// File: rtl/cc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// cc_frame_ctrl
//   Frame-level sequencer for the connected-components labeler. Walks a raster
//   pixel stream producing en/x/y, drains the labeler pipeline with forced
//   background cycles, then sweeps obj_id over every allocated label and emits
//   one record per non-empty label.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 one-cycle pulse, starts a frame from IDLE
//   bus                   pixel handshake + record port (master modport)
//   en, p_force_bg        labeler enable / force p=0 during flush
//   x, y                  current pixel coordinates
//   num_labels            labeler label counter
//   obj_id                label being read back
//   obj_area/obj_x/obj_y  labeler readback for obj_id (READ_LAT cycles)
//   busy                  high outside IDLE
//   done                  one-cycle pulse at end of sweep
// -----------------------------------------------------------------------------
module cc_frame_ctrl #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int LOC_SIZE     = 10,
    parameter int LBL_WIDTH    = 8,
    parameter int FLUSH_CYCLES = 4,
    parameter int READ_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    cc_frame_ctrl_if.master      bus,
    output logic                 en,
    output logic                 p_force_bg,
    output logic [LOC_SIZE-1:0]  x,
    output logic [LOC_SIZE-1:0]  y,
    input  logic [LBL_WIDTH-1:0] num_labels,
    output logic [LBL_WIDTH-1:0] obj_id,
    input  logic [LOC_SIZE-1:0]  obj_area,
    input  logic [LOC_SIZE-1:0]  obj_x,
    input  logic [LOC_SIZE-1:0]  obj_y,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FRAME, S_FLUSH, S_ISSUE, S_WAIT, S_PRESENT, S_DONE
    } state_t;

    typedef struct packed {
        logic [LBL_WIDTH-1:0] id;
        logic [LOC_SIZE-1:0]  area;
        logic [LOC_SIZE-1:0]  xs;
        logic [LOC_SIZE-1:0]  ys;
    } rec_t;

    // One counter serves both the flush length and the readback wait.
    localparam int CNT_MAX = (FLUSH_CYCLES > READ_LAT) ? FLUSH_CYCLES : READ_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [LOC_SIZE-1:0]  X_LAST     = LOC_SIZE'(WIDTH - 1);
    localparam logic [LOC_SIZE-1:0]  Y_LAST     = LOC_SIZE'(HEIGHT - 1);
    localparam logic [CNT_W-1:0]     FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]     WAIT_LAST  = CNT_W'(READ_LAT - 1);
    localparam logic [LBL_WIDTH-1:0] ID_ONE     = LBL_WIDTH'(1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [LOC_SIZE-1:0]  x_q, y_q;
    rec_t                 rec_q;
    logic [LBL_WIDTH-1:0] nxt_id;
    logic                 accept;

    assign accept = (state == S_FRAME) && bus.pix_valid;
    assign nxt_id = obj_id + ID_ONE;

    // The end-of-sweep test (obj_id >= num_labels) is made on the transition
    // into ISSUE, so an exhausted sweep goes straight to DONE without spending
    // an ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            obj_id <= '0;
            rec_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FRAME;
                        x_q   <= '0;
                        y_q   <= '0;
                    end
                end
                S_FRAME: begin
                    if (accept) begin
                        if (x_q == X_LAST) begin
                            if (y_q == Y_LAST) begin
                                // last pixel: x/y hold through the flush
                                state <= S_FLUSH;
                                cnt   <= '0;
                            end else begin
                                x_q <= '0;
                                y_q <= y_q + LOC_SIZE'(1);
                            end
                        end else begin
                            x_q <= x_q + LOC_SIZE'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        obj_id <= ID_ONE;
                        state  <= (ID_ONE >= num_labels) ? S_DONE : S_ISSUE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        rec_q <= '{id: obj_id, area: obj_area, xs: obj_x, ys: obj_y};
                        if (obj_area == '0) begin
                            obj_id <= nxt_id;
                            state  <= (nxt_id >= num_labels) ? S_DONE : S_ISSUE;
                        end else begin
                            state <= S_PRESENT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (bus.rec_ready) begin
                        obj_id <= nxt_id;
                        state  <= (nxt_id >= num_labels) ? S_DONE : S_ISSUE;
                    end
                end
                S_DONE: begin
                    // return every output to its idle value
                    state  <= S_IDLE;
                    cnt    <= '0;
                    x_q    <= '0;
                    y_q    <= '0;
                    obj_id <= '0;
                    rec_q  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign x             = x_q;
    assign y             = y_q;
    assign en            = accept || (state == S_FLUSH);
    assign p_force_bg    = (state == S_FLUSH);
    assign bus.pix_ready = (state == S_FRAME);
    assign bus.rec_valid = (state == S_PRESENT);
    assign bus.rec_id    = rec_q.id;
    assign bus.rec_area  = rec_q.area;
    assign bus.rec_x     = rec_q.xs;
    assign bus.rec_y     = rec_q.ys;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

endmodule

// File: tb/tb_cc_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cc_frame_ctrl
//   Directed bench for cc_frame_ctrl with a 4x3 frame, 4 flush cycles and a
//   2-cycle registered readback model standing in for the labeler tables.
// -----------------------------------------------------------------------------
module tb_cc_frame_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int LS = 10;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          en, p_force_bg, busy, done;
    logic [LS-1:0] x, y;
    logic [LW-1:0] num_labels, obj_id;
    logic [LS-1:0] obj_area, obj_x, obj_y;
    logic [3*LS-1:0] rd1, rd2;

    int errs   = 0;
    int checks = 0;

    cc_frame_ctrl_if #(.LOC_SIZE(LS), .LBL_WIDTH(LW)) bus_if ();

    cc_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .LOC_SIZE(LS), .LBL_WIDTH(LW),
        .FLUSH_CYCLES(4), .READ_LAT(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bus(bus_if),
        .en(en), .p_force_bg(p_force_bg), .x(x), .y(y),
        .num_labels(num_labels), .obj_id(obj_id),
        .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Label features {area, xsum, ysum}; id 2 is an empty label.
    function automatic logic [3*LS-1:0] feat(input logic [LW-1:0] id);
        case (id)
            8'd1:    return {10'd5, 10'd7, 10'd11};
            8'd3:    return {10'd2, 10'd9, 10'd13};
            default: return '0;
        endcase
    endfunction

    // Two register stages: data valid READ_LAT=2 cycles after obj_id changes.
    always @(posedge clk) begin
        rd1 <= feat(obj_id);
        rd2 <= rd1;
    end
    assign {obj_area, obj_x, obj_y} = rd2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, "_en"},    32'(en), 0);
        check({tag, "_rdy"},   32'(bus_if.pix_ready), 0);
        check({tag, "_fbg"},   32'(p_force_bg), 0);
        check({tag, "_x"},     32'(x), 0);
        check({tag, "_y"},     32'(y), 0);
        check({tag, "_id"},    32'(obj_id), 0);
        check({tag, "_rv"},    32'(bus_if.rec_valid), 0);
        check({tag, "_rid"},   32'(bus_if.rec_id), 0);
        check({tag, "_rarea"}, 32'(bus_if.rec_area), 0);
        check({tag, "_rx"},    32'(bus_if.rec_x), 0);
        check({tag, "_ry"},    32'(bus_if.rec_y), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
    endtask

    task automatic flush_chk(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus_if.pix_valid = 1'b0;
            #1;
            check({tag, "_en"},  32'(en), 1);
            check({tag, "_fbg"}, 32'(p_force_bg), 1);
            check({tag, "_rdy"}, 32'(bus_if.pix_ready), 0);
            check({tag, "_x"},   32'(x), 3);
            check({tag, "_y"},   32'(y), 2);
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; num_labels = 8'd1;
        bus_if.pix_valid = 1'b0; bus_if.rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        idle_chk("reset");
        reset_n = 1'b1;
        step();
        idle_chk("idle");

        // Frame 1: continuous pixels, num_labels=1 -> no records.
        bus_if.pix_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("f1_en",  32'(en), 1);
            check("f1_rdy", 32'(bus_if.pix_ready), 1);
            check("f1_x",   32'(x), 32'(i % 4));
            check("f1_y",   32'(y), 32'(i / 4));
            step();
        end
        flush_chk("f1_flush");
        #1;
        check("f1_done",    32'(done), 1);
        check("f1_done_rv", 32'(bus_if.rec_valid), 0);
        step();
        idle_chk("f1_end");

        // Frame 2: 3-cycle gap at pixel 5, then sweep with num_labels=4.
        num_labels = 8'd4;
        bus_if.pix_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 5) begin
                for (int g = 0; g < 3; g++) begin
                    bus_if.pix_valid = 1'b0;
                    #1;
                    check("gap_en", 32'(en), 0);
                    check("gap_x",  32'(x), 1);
                    check("gap_y",  32'(y), 1);
                    step();
                end
            end
            bus_if.pix_valid = 1'b1;
            #1;
            check("f2_en", 32'(en), 1);
            check("f2_x",  32'(x), 32'(k % 4));
            check("f2_y",  32'(y), 32'(k / 4));
            step();
        end
        flush_chk("f2_flush");
        #1;
        check("issue1_id", 32'(obj_id), 1);
        check("issue1_rv", 32'(bus_if.rec_valid), 0);
        check("issue1_en", 32'(en), 0);
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_rv",   32'(bus_if.rec_valid), 1);
            check("hold_rid",  32'(bus_if.rec_id), 1);
            check("hold_area", 32'(bus_if.rec_area), 5);
            check("hold_x",    32'(bus_if.rec_x), 7);
            check("hold_y",    32'(bus_if.rec_y), 11);
            check("hold_id",   32'(obj_id), 1);
            step();
        end
        bus_if.rec_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("id2_id", 32'(obj_id), 2);
            check("id2_rv", 32'(bus_if.rec_valid), 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            check("id3_id", 32'(obj_id), 3);
            check("id3_rv", 32'(bus_if.rec_valid), 0);
            step();
        end
        #1;
        check("rec3_rv",   32'(bus_if.rec_valid), 1);
        check("rec3_rid",  32'(bus_if.rec_id), 3);
        check("rec3_area", 32'(bus_if.rec_area), 2);
        check("rec3_x",    32'(bus_if.rec_x), 9);
        check("rec3_y",    32'(bus_if.rec_y), 13);
        step();
        #1;
        check("f2_done",    32'(done), 1);
        check("f2_done_rv", 32'(bus_if.rec_valid), 0);
        step();
        bus_if.rec_ready = 1'b0;
        idle_chk("f2_end");

        // Frame 3: ignored start mid-frame, reset at (2,1), then restart.
        bus_if.pix_valid = 1'b1; start = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            start = (i == 3);
            #1;
            check("f3_x", 32'(x), 32'(i % 4));
            check("f3_y", 32'(y), 32'(i / 4));
            step();
        end
        start = 1'b0;
        #1;
        check("f3_at_x", 32'(x), 2);
        check("f3_at_y", 32'(y), 1);
        reset_n = 1'b0;
        #1;
        idle_chk("mid_rst");
        step();
        idle_chk("mid_rst_hold");
        reset_n = 1'b1;
        step();
        idle_chk("post_rst");
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check("restart_x",  32'(x), 0);
        check("restart_y",  32'(y), 0);
        check("restart_en", 32'(en), 1);
        step();
        #1;
        check("restart_x1", 32'(x), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cc_frame_ctrl.md
# cc_frame_ctrl

Frame-level sequencer for `connected_components_labeling`. Accepts a raster pixel stream and generates `en`, `x` and `y` for the labeler. After the last pixel it drains the labeler pipeline with forced-background cycles. It then sweeps `obj_id` over every allocated label and emits one object record (id, area, x-sum, y-sum) per non-empty label on a valid/ready output port.

## Interface
Parameters:
- `WIDTH`, 640, pixels per line
- `HEIGHT`, 480, lines per frame
- `LOC_SIZE`, 10, coordinate / feature width; matches the global define
- `LBL_WIDTH`, 8, label width; matches the global define
- `FLUSH_CYCLES`, 4, forced-background `en` cycles after the last pixel
- `READ_LAT`, 2, cycles from `obj_id` change to stable `obj_area/obj_x/obj_y` (merge-table read, then data-table read)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a frame when in IDLE
- `pix_valid`  in  1  upstream pixel available
- `pix_ready`  out  1  controller accepts a pixel this cycle
- `en`  out  1  labeler enable
- `p_force_bg`  out  1  top level must drive labeler `p`=0 while high
- `x`  out  LOC_SIZE  column of the current pixel
- `y`  out  LOC_SIZE  row of the current pixel
- `num_labels`  in  LBL_WIDTH  labeler label counter
- `obj_id`  out  LBL_WIDTH  label being read back
- `obj_area`, `obj_x`, `obj_y`  in  LOC_SIZE  labeler readback for `obj_id`
- `rec_valid`  out  1  record available
- `rec_ready`  in  1  downstream accepts the record
- `rec_id`  out  LBL_WIDTH  record label
- `rec_area`, `rec_x`, `rec_y`  out  LOC_SIZE  record features
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of sweep

## Operation
States: IDLE, FRAME, FLUSH, ISSUE, WAIT, PRESENT, DONE.
- **IDLE.** All outputs are 0 (this is also the reset value). `start` moves to FRAME with x=y=0. `start` in any other state is ignored.
- **FRAME.**
  - `pix_ready`=1 and `en`=`pix_valid`.
  - On each accepted pixel, x increments. At x=WIDTH-1, x wraps to 0 and y increments.
  - Accepting pixel (WIDTH-1, HEIGHT-1) moves to FLUSH. x and y hold their last values.
- **FLUSH.** `pix_ready`=0, `en`=1, `p_force_bg`=1 for exactly FLUSH_CYCLES cycles. Then go to ISSUE with `obj_id`=1.
- **ISSUE / WAIT.**
  - If `obj_id` ≥ `num_labels` (sampled on entering ISSUE), go to DONE.
  - Otherwise hold `obj_id` and stay in WAIT for READ_LAT cycles, then capture `obj_area/obj_x/obj_y`.
  - If the captured area is 0, increment `obj_id` and return to ISSUE. Otherwise go to PRESENT.
- **PRESENT.**
  - `rec_valid`=1 and the `rec_*` outputs are stable.
  - On `rec_valid & rec_ready`, increment `obj_id` and go to ISSUE.
  - If `rec_ready` stays low, the record holds indefinitely.
- **DONE.** `done`=1 for one cycle, then IDLE.
- Merged (non-root) labels resolve to their root's statistics. Records are emitted per id, so duplicates are permitted. Deduplication belongs downstream.
- Arithmetic: x, y and `obj_id` are unsigned and never exceed their bounds. `obj_id` stops at `num_labels`, which is at most MAX_LABEL-1, so it cannot wrap.

## Timing
- `en`, `x`, `y` and `pix_ready` are combinational from state and registered counters. A pixel presented with x=k is accepted in the same cycle.
- FLUSH takes FLUSH_CYCLES cycles. Each empty id costs 1+READ_LAT cycles. Each non-empty id costs 1+READ_LAT+(cycles to `rec_ready`).
- `rec_*` outputs are registered. They update only on capture, never while `rec_valid`=1 without a handshake.
- `reset_n` low at any time forces IDLE, zeros all outputs, and discards the in-flight frame or record. There is no deferred `done`.
- A `pix_valid` gap in FRAME stalls x/y and holds `en`=0. The labeler pipeline freezes with it.

## Test plan
- WIDTH=4, HEIGHT=3, FLUSH_CYCLES=4, continuous `pix_valid`, `start` pulse -> 12 consecutive `en` cycles with (x,y) sequence (0,0)…(3,0),(0,1)…(3,2); then 4 cycles `en`=1, `p_force_bg`=1, `pix_ready`=0.
- Same frame with `pix_valid` low at pixel 5 for 3 cycles -> `en`=0 and x=1, y=1 held for 3 cycles; totals unchanged.
- Sweep with `num_labels`=4, areas {id1:5, id2:0, id3:2}, `rec_ready`=1 -> two records, (1,5,…) then (3,2,…); `done` 1 cycle after the second handshake; id 2 is never presented.
- `rec_ready` low for 10 cycles in PRESENT -> `rec_valid` and `rec_*` constant; `obj_id` unchanged.
- `num_labels`=1 -> no records; `done` is asserted on the cycle after FLUSH ends.
- `reset_n` asserted mid-FRAME at (2,1), then released, then `start` -> all outputs 0 during reset; new frame restarts at (0,0); `start` pulses during FRAME are ignored.
